// File: rtl/ssm_pkt_buffer.sv
// Store-and-forward buffer for the FAST 134-bit word stream: commits whole packets only, drops overflow/malformed ones.
// Optional build macro SSM_BUF_LEN_CHECK_EN adds a per-packet word-count vs. header-length check.
module ssm_pkt_buffer #(
    parameter int DEPTH_LOG2 = 8,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [133:0]          pktin_data,
    input  logic                  pktin_data_wr,
    output logic [133:0]          pktout_data,
    output logic                  pktout_data_wr,
    input  logic                  pktout_data_alf,
    output logic [DEPTH_LOG2:0]   buf_used_words,
    output logic [CNT_W-1:0]      pkt_out_cnt,
    output logic [CNT_W-1:0]      pkt_drop_cnt
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_e;

    wstate_e           state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     start_ptr_q, start_ptr_d;
    logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [133:0]      out_data_q;
    logic              out_wr_q;
    logic              alf_q;
    logic [PW-1:0]     used_q;

    logic [133:0]          mem [0:(1<<DEPTH_LOG2)-1];
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [133:0]          rd_word;
    logic                  rd_en;

    logic [1:0]    wtype;
    logic [PW-1:0] base_ptr;
    logic          full_wr;
    logic          full_base;
    logic          len_ok;

    assign wtype = pktin_data[133:132];
    // A new packet starts at wr_ptr when idle, otherwise at the rewound start of the abandoned packet.
    assign base_ptr  = (state_q == W_IDLE) ? wr_ptr_q : start_ptr_q;
    assign full_wr   = (wr_ptr_q - rd_ptr_q) == DEPTH;
    assign full_base = (base_ptr - rd_ptr_q) == DEPTH;

`ifdef SSM_BUF_LEN_CHECK_EN
    logic [11:0] len_q, len_d;
    logic [15:0] wcnt_q, wcnt_d;

    assign len_ok = (wcnt_q + 16'd1) == ((({4'b0, len_q} + 16'd15) >> 4) + 16'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            wcnt_q <= '0;
        end else begin
            len_q  <= len_d;
            wcnt_q <= wcnt_d;
        end
    end
`else
    assign len_ok = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        start_ptr_d  = start_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_cnt_d   = drop_cnt_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr_q[DEPTH_LOG2-1:0];
`ifdef SSM_BUF_LEN_CHECK_EN
        len_d  = len_q;
        wcnt_d = wcnt_q;
`endif
        if (pktin_data_wr) begin
            case (wtype)
                2'b01: begin
                    if (state_q != W_IDLE) drop_cnt_d = drop_cnt_q + 1'b1;
                    start_ptr_d = base_ptr;
                    if (full_base) begin
                        state_d  = W_DROP;
                        wr_ptr_d = base_ptr;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = base_ptr[DEPTH_LOG2-1:0];
                        wr_ptr_d  = base_ptr + 1'b1;
                        state_d   = W_PKT;
`ifdef SSM_BUF_LEN_CHECK_EN
                        wcnt_d = 16'd1;
                        len_d  = pktin_data[107:96];
`endif
                    end
                end
                2'b11: begin
                    if (state_q == W_PKT) begin
                        if (full_wr) begin
                            state_d  = W_DROP;
                            wr_ptr_d = start_ptr_q;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef SSM_BUF_LEN_CHECK_EN
                            wcnt_d = wcnt_q + 16'd1;
`endif
                        end
                    end
                end
                2'b10: begin
                    if (state_q == W_PKT) begin
                        state_d = W_IDLE;
                        if (full_wr || !len_ok) begin
                            wr_ptr_d   = start_ptr_q;
                            drop_cnt_d = drop_cnt_q + 1'b1;
                        end else begin
                            mem_we       = 1'b1;
                            wr_ptr_d     = wr_ptr_q + 1'b1;
                            commit_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end else if (state_q == W_DROP) begin
                        state_d    = W_IDLE;
                        drop_cnt_d = drop_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read side: alf is registered, so downstream sees at most one word after raising it.
    assign rd_en   = (commit_ptr_q != rd_ptr_q) && !alf_q;
    assign rd_word = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        out_cnt_d = out_cnt_q;
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_word[133:132] == 2'b10) out_cnt_d = out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= pktin_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= W_IDLE;
            wr_ptr_q     <= '0;
            start_ptr_q  <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            drop_cnt_q   <= '0;
            out_cnt_q    <= '0;
            out_data_q   <= '0;
            out_wr_q     <= 1'b0;
            alf_q        <= 1'b0;
            used_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            start_ptr_q  <= start_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_cnt_q   <= drop_cnt_d;
            out_cnt_q    <= out_cnt_d;
            out_data_q   <= rd_en ? rd_word : '0;
            out_wr_q     <= rd_en;
            alf_q        <= pktout_data_alf;
            used_q       <= commit_ptr_d - rd_ptr_d;
        end
    end

    assign pktout_data    = out_data_q;
    assign pktout_data_wr = out_wr_q;
    assign buf_used_words = used_q;
    assign pkt_out_cnt    = out_cnt_q;
    assign pkt_drop_cnt   = drop_cnt_q;

endmodule
